// File: rtl/knight_rider_pkg.sv
// Shared types for the Knight Rider LED scanner.
package knight_rider_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_UP   = 2'd1,
      ST_DN   = 2'd2
   } scan_state_e;

   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;

   // Running state that matches a given travel direction
   function automatic scan_state_e dir_state(input logic dir);
      return (dir == DIR_DN) ? ST_DN : ST_UP;
   endfunction

endpackage

// File: rtl/kr_tick_gen.sv
// Step-rate prescaler: one-cycle strobe every TICK_DIV enabled cycles.
// Counter is cleared whenever the enable is low, so the first strobe
// lands TICK_DIV cycles after the enable rises.
module kr_tick_gen #(
   parameter int unsigned TICK_DIV = 4
) (
   input  logic clk_i,
   input  logic sys_rst_i,
   input  logic en_i,
   output logic step_o
);

   localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

   logic [TICK_W-1:0] tick_q;

   // Count 0..TICK_DIV-1 while enabled, wrap on the strobe
   always_ff @(posedge clk_i) begin
      if (!sys_rst_i) begin
         tick_q <= '0;
      end else if (!en_i || (tick_q == TICK_LAST)) begin
         tick_q <= '0;
      end else begin
         tick_q <= tick_q + TICK_W'(1);
      end
   end

   assign step_o = en_i && (tick_q == TICK_LAST);

endmodule

// File: rtl/knight_rider_scanner.sv
// Knight Rider bounce scanner: one lit LED sweeping 0 -> N-1 -> 0.
// Optional build macro KR_TRAIL_EN adds a PWM-faded trail behind the head.
module knight_rider_scanner
   import knight_rider_pkg::*;
#(
   parameter int unsigned N_LEDS    = 8,
   parameter int unsigned TICK_DIV  = 4
`ifdef KR_TRAIL_EN
   ,
   parameter int unsigned PWM_BITS  = 3,
   parameter int unsigned TRAIL_LEN = 3
`endif
) (
   input  logic                      clk_i,
   input  logic                      sys_rst_i,
   input  logic                      run_i,
   output logic [N_LEDS-1:0]         leds_o,
   output logic [$clog2(N_LEDS)-1:0] pos_o,
   output logic                      dir_o,
   output logic                      end_o
);

   localparam int unsigned POS_W = $clog2(N_LEDS);

   scan_state_e       state_q;
   logic              step;
   logic              adv;
   logic [POS_W-1:0]  step_pos;
   logic              step_dir;
   logic              step_rev;
   logic [POS_W-1:0]  head_nx;
   logic [N_LEDS-1:0] leds_nx;

   kr_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk_i     (clk_i),
      .sys_rst_i (sys_rst_i),
      .en_i      (run_i),
      .step_o    (step)
   );

   assign adv     = run_i && step;
   assign head_nx = adv ? step_pos : pos_o;

   // Position/direction after one step, bouncing off either end
   always_comb begin
      step_pos = pos_o;
      step_dir = dir_o;
      step_rev = 1'b0;
      if (dir_o == DIR_UP) begin
         if (pos_o == POS_W'(N_LEDS - 1)) begin
            step_pos = POS_W'(N_LEDS - 2);
            step_dir = DIR_DN;
            step_rev = 1'b1;
         end else begin
            step_pos = pos_o + POS_W'(1);
         end
      end else begin
         if (pos_o == '0) begin
            step_pos = POS_W'(1);
            step_dir = DIR_UP;
            step_rev = 1'b1;
         end else begin
            step_pos = pos_o - POS_W'(1);
         end
      end
   end

   // Scan FSM: freeze in IDLE, resume in the saved direction
   always_ff @(posedge clk_i) begin
      if (!sys_rst_i) begin
         state_q <= ST_IDLE;
         pos_o   <= '0;
         dir_o   <= DIR_UP;
         end_o   <= 1'b0;
      end else begin
         end_o <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (run_i) begin
                  if (adv) begin
                     pos_o   <= step_pos;
                     dir_o   <= step_dir;
                     end_o   <= step_rev;
                     state_q <= dir_state(step_dir);
                  end else begin
                     state_q <= dir_state(dir_o);
                  end
               end
            end
            ST_UP, ST_DN: begin
               if (!run_i) begin
                  state_q <= ST_IDLE;
               end else if (adv) begin
                  pos_o   <= step_pos;
                  dir_o   <= step_dir;
                  end_o   <= step_rev;
                  state_q <= dir_state(step_dir);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef KR_TRAIL_EN
   logic [PWM_BITS-1:0] pwm_q;
   logic [PWM_BITS-1:0] pwm_nx;
   logic [POS_W-1:0]    hist_q  [TRAIL_LEN];
   logic [POS_W-1:0]    hist_nx [TRAIL_LEN];
   logic [PWM_BITS:0]   pwm_full;

   assign pwm_nx   = pwm_q + PWM_BITS'(1);
   assign pwm_full = {1'b1, {PWM_BITS{1'b0}}};

   // History of previous heads, shifted on each step
   always_comb begin
      for (int k = 0; k < int'(TRAIL_LEN); k++) begin
         hist_nx[k] = hist_q[k];
      end
      if (adv) begin
         hist_nx[0] = pos_o;
         for (int k = 1; k < int'(TRAIL_LEN); k++) begin
            hist_nx[k] = hist_q[k-1];
         end
      end
   end

   // Head fully on, trail position k on for 2**PWM_BITS >> k counts
   always_comb begin
      leds_nx          = '0;
      leds_nx[head_nx] = 1'b1;
      for (int k = 1; k <= int'(TRAIL_LEN); k++) begin
         if ({1'b0, pwm_nx} < (pwm_full >> k)) begin
            leds_nx[hist_nx[k-1]] = 1'b1;
         end
      end
   end

   // Free-running PWM counter and trail history registers
   always_ff @(posedge clk_i) begin
      if (!sys_rst_i) begin
         pwm_q <= '0;
         for (int k = 0; k < int'(TRAIL_LEN); k++) begin
            hist_q[k] <= '0;
         end
      end else begin
         pwm_q <= pwm_nx;
         for (int k = 0; k < int'(TRAIL_LEN); k++) begin
            hist_q[k] <= hist_nx[k];
         end
      end
   end
`else
   // Plain one-hot of the upcoming head position
   always_comb begin
      leds_nx          = '0;
      leds_nx[head_nx] = 1'b1;
   end
`endif

   // Registered LED drive toward the pins
   always_ff @(posedge clk_i) begin
      if (!sys_rst_i) begin
         leds_o <= N_LEDS'(1);
      end else begin
         leds_o <= leds_nx;
      end
   end

endmodule

// File: tb/tb_knight_rider_scanner.sv
// Directed self-checking bench for knight_rider_scanner.
module tb_knight_rider_scanner;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       run;
   logic [7:0] leds;
   logic [2:0] pos;
   logic       dir;
   logic       endp;

   logic       rst2;
   logic       run2;
   logic [1:0] leds2;
   logic [0:0] pos2;
   logic       dir2;
   logic       end2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   knight_rider_scanner #(.N_LEDS(8), .TICK_DIV(4)) u_dut (
      .clk_i     (clk),
      .sys_rst_i (rst_n),
      .run_i     (run),
      .leds_o    (leds),
      .pos_o     (pos),
      .dir_o     (dir),
      .end_o     (endp)
   );

   knight_rider_scanner #(.N_LEDS(2), .TICK_DIV(1)) u_dut2 (
      .clk_i     (clk),
      .sys_rst_i (rst2),
      .run_i     (run2),
      .leds_o    (leds2),
      .pos_o     (pos2),
      .dir_o     (dir2),
      .end_o     (end2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic expect_scan(input string tag, input int p, input logic d, input logic e);
      check({tag, ".pos"}, 32'(pos), 32'(p));
      check({tag, ".dir"}, 32'(dir), 32'(d));
      check({tag, ".end"}, 32'(endp), 32'(e));
`ifndef KR_TRAIL_EN
      check({tag, ".leds"}, 32'(leds), 32'(1 << p));
`endif
   endtask

   initial begin
      int end_cnt;
      rst_n = 1'b0;
      run   = 1'b1;
      rst2  = 1'b0;
      run2  = 1'b0;

      // Reset held with run high
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst.leds", 32'(leds), 32'h01);
         check("rst.pos",  32'(pos),  32'd0);
         check("rst.dir",  32'(dir),  32'd0);
         check("rst.end",  32'(endp), 32'd0);
      end

      // Scan out and back, then up again to pos 5 on the way down
      rst_n   = 1'b1;
      end_cnt = 0;
      for (int c = 1; c <= 92; c++) begin
         @(negedge clk);
         if (c <= 61) end_cnt += int'(endp);
         case (c)
            3:  expect_scan("scan.c3",  0, 1'b0, 1'b0);
            4:  expect_scan("scan.c4",  1, 1'b0, 1'b0);
            8:  expect_scan("scan.c8",  2, 1'b0, 1'b0);
            28: expect_scan("scan.c28", 7, 1'b0, 1'b0);
            31: expect_scan("scan.c31", 7, 1'b0, 1'b0);
            32: expect_scan("scan.c32", 6, 1'b1, 1'b1);
            33: expect_scan("scan.c33", 6, 1'b1, 1'b0);
            36: expect_scan("scan.c36", 5, 1'b1, 1'b0);
            56: expect_scan("scan.c56", 0, 1'b1, 1'b0);
            60: expect_scan("scan.c60", 1, 1'b0, 1'b1);
            61: expect_scan("scan.c61", 1, 1'b0, 1'b0);
            88: expect_scan("scan.c88", 6, 1'b1, 1'b1);
            92: expect_scan("scan.c92", 5, 1'b1, 1'b0);
            default: ;
         endcase
      end
      check("scan.end_count", 32'(end_cnt), 32'd2);

      // Freeze for 20 cycles, then resume downward
      run = 1'b0;
      @(negedge clk);
      expect_scan("frz.c1", 5, 1'b1, 1'b0);
      repeat (19) @(negedge clk);
      expect_scan("frz.c20", 5, 1'b1, 1'b0);
      run = 1'b1;
      repeat (3) @(negedge clk);
      expect_scan("resume.c3", 5, 1'b1, 1'b0);
      @(negedge clk);
      expect_scan("resume.c4", 4, 1'b1, 1'b0);

      // Reset lands on the same edge as a strobe at pos 6 heading down
      repeat (51) @(negedge clk);
      expect_scan("pre_rst", 6, 1'b1, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst.leds", 32'(leds), 32'h01);
      expect_scan("midrst", 0, 1'b0, 1'b0);
      rst_n = 1'b1;

`ifdef KR_TRAIL_EN
      // Trail after visiting 0,1,2,3 then frozen
      begin
         int cnt [8];
         int exp_cnt [8];
         exp_cnt = '{1, 2, 4, 8, 0, 0, 0, 0};
         for (int b = 0; b < 8; b++) cnt[b] = 0;
         repeat (12) @(negedge clk);
         check("trail.pos", 32'(pos), 32'd3);
         run = 1'b0;
         @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            for (int b = 0; b < 8; b++) cnt[b] += int'(leds[b]);
         end
         for (int b = 0; b < 8; b++) begin
            check($sformatf("trail.led%0d", b), 32'(cnt[b]), 32'(exp_cnt[b]));
         end
      end
`endif

      // Two LEDs, step every cycle
      rst2 = 1'b1;
      run2 = 1'b1;
      @(negedge clk);
      check("n2.c1.pos", 32'(pos2), 32'd1);
      check("n2.c1.end", 32'(end2), 32'd0);
      @(negedge clk);
      check("n2.c2.pos", 32'(pos2), 32'd0);
      check("n2.c2.dir", 32'(dir2), 32'd1);
      check("n2.c2.end", 32'(end2), 32'd1);
      @(negedge clk);
      check("n2.c3.pos", 32'(pos2), 32'd1);
      check("n2.c3.dir", 32'(dir2), 32'd0);
      check("n2.c3.end", 32'(end2), 32'd1);
`ifndef KR_TRAIL_EN
      check("n2.c3.leds", 32'(leds2), 32'h2);
`endif
      @(negedge clk);
      check("n2.c4.pos", 32'(pos2), 32'd0);
      check("n2.c4.end", 32'(end2), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
